// File: rtl/uart_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_bist_pkg
// Purpose  : Shared types and constants for the UART loopback BIST.
// Revision : 1.0 - initial release
// ============================================================================
package uart_bist_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEND    = 2'd1,
    S_WAIT_RX = 2'd2,
    S_FINISH  = 2'd3
  } bist_state_e;

  // Taps for x^8+x^6+x^5+x^4+1 mapped onto bits [7:0]
  localparam logic [7:0] LFSR_TAPS     = 8'hB8;
  localparam logic [7:0] PRBS_SEED_FIX = 8'h01;

endpackage
`default_nettype wire

// File: rtl/uart_bist_pattern.sv
`default_nettype none
// ============================================================================
// Module   : uart_bist_pattern
// Purpose  : Test byte generator; incrementing by default, 8-bit Fibonacci
//            LFSR when UART_BIST_PRBS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module uart_bist_pattern
  import uart_bist_pkg::*;
(
  input  logic       clk,
  input  logic       nReset,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       advance,
  output logic [7:0] pattern
);

  logic [7:0] r_pattern;
  logic [7:0] w_load_val;
  logic [7:0] w_next_val;

`ifdef UART_BIST_PRBS_EN
  // An all-zero LFSR never leaves zero
  assign w_load_val = (seed == 8'h00) ? PRBS_SEED_FIX : seed;
  assign w_next_val = {r_pattern[6:0], ^(r_pattern & LFSR_TAPS)};
`else
  assign w_load_val = seed;
  assign w_next_val = r_pattern + 8'h01;
`endif

  always_ff @(posedge clk) begin
    if (!nReset) begin
      r_pattern <= 8'h00;
    end else if (load) begin
      r_pattern <= w_load_val;
    end else if (advance) begin
      r_pattern <= w_next_val;
    end
  end

  assign pattern = r_pattern;

endmodule
`default_nettype wire

// File: rtl/uart_loopback_bist.sv
`default_nettype none
// ============================================================================
// Module   : uart_loopback_bist
// Purpose  : BIST sequencer for a UART TX->RX loopback; sends a byte pattern,
//            checks the echo, counts errors. Pattern set by UART_BIST_PRBS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_loopback_bist
  import uart_bist_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_bytes,
  input  logic [7:0]       seed,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_busy,
  input  logic [7:0]       rx_data,
  input  logic             rx_done,
  input  logic             rx_err,
  output logic             running,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_fail
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IDX_W = CNT_W + 1;

  bist_state_e      r_state,      w_state_nxt;
  logic [CNT_W-1:0] r_num_bytes;
  logic [CNT_W-1:0] r_index,      w_index_nxt;
  logic [CNT_W-1:0] r_err_count,  w_err_nxt;
  logic [CNT_W-1:0] r_first_fail, w_ff_nxt;
  logic             r_pass,       w_pass_nxt;
  logic             r_running,    w_running_nxt;
  logic             r_done,       w_done_nxt;
  logic             r_tx_valid,   w_tx_valid_nxt;
  logic [7:0]       r_tx_data,    w_tx_data_nxt;
  logic [TMO_W-1:0] r_tmo_cnt,    w_tmo_nxt;

  logic             w_load;
  logic             w_advance;
  logic             w_byte_bad;
  logic             w_timeout;
  logic [IDX_W-1:0] w_index_inc;
  logic [7:0]       w_pattern;

  uart_bist_pattern u_pattern (
    .clk     (clk),
    .nReset  (nReset),
    .load    (w_load),
    .seed    (seed),
    .advance (w_advance),
    .pattern (w_pattern)
  );

  assign w_timeout   = (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign w_index_inc = {1'b0, r_index} + IDX_W'(1);

  always_comb begin
    w_state_nxt    = r_state;
    w_index_nxt    = r_index;
    w_err_nxt      = r_err_count;
    w_ff_nxt       = r_first_fail;
    w_pass_nxt     = r_pass;
    w_running_nxt  = r_running;
    w_done_nxt     = 1'b0;
    w_tx_valid_nxt = 1'b0;
    w_tx_data_nxt  = r_tx_data;
    w_tmo_nxt      = r_tmo_cnt;
    w_load         = 1'b0;
    w_advance      = 1'b0;
    w_byte_bad     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load        = 1'b1;
          w_index_nxt   = '0;
          w_err_nxt     = '0;
          w_ff_nxt      = '1;
          w_pass_nxt    = 1'b0;
          w_running_nxt = 1'b1;
          w_state_nxt   = (num_bytes == '0) ? S_FINISH : S_SEND;
        end
      end

      S_SEND: begin
        if (!tx_busy) begin
          w_tx_valid_nxt = 1'b1;
          w_tx_data_nxt  = w_pattern;
          w_tmo_nxt      = '0;
          w_state_nxt    = S_WAIT_RX;
        end
      end

      S_WAIT_RX: begin
        // A receive in the timeout cycle takes priority over the timeout
        if (rx_done || w_timeout) begin
          w_byte_bad = rx_done ? (rx_err || (rx_data != w_pattern)) : 1'b1;
          if (w_byte_bad) begin
            if (r_err_count != '1) begin
              w_err_nxt = r_err_count + CNT_W'(1);
            end
            if (r_first_fail == '1) begin
              w_ff_nxt = r_index;
            end
          end
          w_advance   = 1'b1;
          w_index_nxt = w_index_inc[CNT_W-1:0];
          w_state_nxt = (w_index_inc < {1'b0, r_num_bytes}) ? S_SEND : S_FINISH;
        end else begin
          w_tmo_nxt = r_tmo_cnt + TMO_W'(1);
        end
      end

      S_FINISH: begin
        w_done_nxt    = 1'b1;
        w_pass_nxt    = (r_err_count == '0);
        w_running_nxt = 1'b0;
        w_state_nxt   = S_IDLE;
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      r_state      <= S_IDLE;
      r_num_bytes  <= '0;
      r_index      <= '0;
      r_err_count  <= '0;
      r_first_fail <= '1;
      r_pass       <= 1'b0;
      r_running    <= 1'b0;
      r_done       <= 1'b0;
      r_tx_valid   <= 1'b0;
      r_tx_data    <= 8'h00;
      r_tmo_cnt    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_index      <= w_index_nxt;
      r_err_count  <= w_err_nxt;
      r_first_fail <= w_ff_nxt;
      r_pass       <= w_pass_nxt;
      r_running    <= w_running_nxt;
      r_done       <= w_done_nxt;
      r_tx_valid   <= w_tx_valid_nxt;
      r_tx_data    <= w_tx_data_nxt;
      r_tmo_cnt    <= w_tmo_nxt;
      if (w_load) begin
        r_num_bytes <= num_bytes;
      end
    end
  end

  assign tx_data    = r_tx_data;
  assign tx_valid   = r_tx_valid;
  assign running    = r_running;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_count  = r_err_count;
  assign first_fail = r_first_fail;

endmodule
`default_nettype wire
